// File: rtl/adder_seq_ctrl.sv
// Multi-cycle wide adder: one 4-bit slice walks the operands LSB nibble first with a registered carry.
// Optional macro ADDER_SEQ_EARLY_DONE_EN finishes as soon as the remaining operand nibbles are zero and no carry is pending.

module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module adder_seq_ctrl #(
    parameter int NUM_NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    input  logic [4*NUM_NIBBLES-1:0] op_a,
    input  logic [4*NUM_NIBBLES-1:0] op_b,
    input  logic                     carry_in,
    output logic                     busy,
    output logic                     done,
    output logic [4*NUM_NIBBLES-1:0] sum,
    output logic                     overflow
);
    localparam int W  = 4 * NUM_NIBBLES;
    localparam int CW = $clog2(NUM_NIBBLES);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t        state_reg;
    logic [W-1:0]  a_reg, b_reg, acc_reg, sum_reg;
    logic [W-1:0]  acc_next;
    logic          carry_reg, overflow_reg, busy_reg, done_reg;
    logic [CW-1:0] cnt_reg;

    logic [3:0]    a_nib [NUM_NIBBLES];
    logic [3:0]    b_nib [NUM_NIBBLES];
    logic [3:0]    slice_sum;
    logic          slice_cout;
    logic          last_step;

    // Nibble views of the captured operands and the working result with the current nibble replaced.
    generate
        for (genvar gi = 0; gi < NUM_NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = b_reg[4*gi +: 4];
            assign acc_next[4*gi +: 4] = (cnt_reg == CW'(gi)) ? slice_sum : acc_reg[4*gi +: 4];
        end
    endgenerate

    adder_4bit u_slice (
        .a    (a_nib[cnt_reg]),
        .b    (b_nib[cnt_reg]),
        .cin  (carry_reg),
        .s    (slice_sum),
        .cout (slice_cout)
    );

`ifdef ADDER_SEQ_EARLY_DONE_EN
    // upper_zero[i]: every captured operand bit above nibble i is zero.
    logic upper_zero [NUM_NIBBLES];
    generate
        for (genvar gi = 0; gi < NUM_NIBBLES - 1; gi++) begin : g_zero
            assign upper_zero[gi] = ~|(a_reg[W-1:4*(gi+1)] | b_reg[W-1:4*(gi+1)]);
        end
    endgenerate
    assign upper_zero[NUM_NIBBLES-1] = 1'b1;
    assign last_step = (cnt_reg == LAST_IDX) || (upper_zero[cnt_reg] && !slice_cout);
`else
    assign last_step = (cnt_reg == LAST_IDX);
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg    <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            acc_reg      <= '0;
            sum_reg      <= '0;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_reg     <= op_a;
                        b_reg     <= op_b;
                        carry_reg <= carry_in;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ADD;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                ADD: begin
                    acc_reg   <= acc_next;
                    carry_reg <= slice_cout;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (last_step) begin
                        sum_reg      <= acc_next;
                        overflow_reg <= slice_cout;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        state_reg    <= DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign sum      = sum_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Randomized bench for adder_seq_ctrl against a transaction-level model (sum = a+b+cin, latency from result size).
// Honours ADDER_SEQ_EARLY_DONE_EN for the expected latency.

module tb_adder_seq_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic         carry_in = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy, done, overflow;
    logic [W-1:0] sum;

    int vectors = 0;
    int miscompares = 0;

    adder_seq_ctrl #(.NUM_NIBBLES(N)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Cycles an operation occupies: full width normally, otherwise just enough nibbles to hold the full result.
    function automatic int lat_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
`ifdef ADDER_SEQ_EARLY_DONE_EN
        for (int i = 1; i < N; i++)
            if ((s >> (4 * i)) == '0) return i;
        return N;
`else
        return (s == '0) ? N : N;
`endif
    endfunction

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model.
    logic         busy_m = 1'b0, done_m = 1'b0, ov_m = 1'b0;
    logic [W-1:0] sum_m = '0;
    logic [W:0]   pend = '0;
    int           remain = 0;
    int           accepted = 0;
    int           done_seen = 0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy_m <= 1'b0;
            done_m <= 1'b0;
            ov_m   <= 1'b0;
            sum_m  <= '0;
            remain <= 0;
        end else if (busy_m) begin
            if (remain == 1) begin
                busy_m          <= 1'b0;
                done_m          <= 1'b1;
                {ov_m, sum_m}   <= pend;
            end
            remain <= remain - 1;
        end else begin
            done_m <= 1'b0;
            if (start) begin
                busy_m   <= 1'b1;
                pend     <= {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, carry_in};
                remain   <= lat_f(op_a, op_b, carry_in);
                accepted <= accepted + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", (W+1)'(busy), (W+1)'(busy_m));
        check("done", (W+1)'(done), (W+1)'(done_m));
        check("sum", (W+1)'(sum), (W+1)'(sum_m));
        check("overflow", (W+1)'(overflow), (W+1)'(ov_m));
        if (done === 1'b1) done_seen++;
    end

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic [W-1:0] exp_sum, input logic exp_ov, input int exp_lat);
        int lat;
        @(posedge clk); #1;
        op_a = a; op_b = b; carry_in = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); carry_in = 1'($urandom);
        wait_done(lat);
        check({name, "_lat"}, (W+1)'(lat), (W+1)'(exp_lat));
        check({name, "_res"}, {overflow, sum}, {exp_ov, exp_sum});
        check({name, "_model"}, {ov_m, sum_m}, {exp_ov, exp_sum});
        $display("op %s: %h + %h + %0d -> sum %h ovf %0d in %0d cycles", name, a, b, c, sum, overflow, lat);
    endtask

    initial begin
        int lat;
        int acc0, done0, budget;
        logic [W-1:0] ra, rb;

        repeat (2) @(posedge clk);
        #2 n_rst = 1'b1;

        run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 4);

        // Asynchronous reset mid-cycle clears outputs immediately.
        @(posedge clk); #2 n_rst = 1'b0;
        #1 check("rst_async", {done, busy, overflow, sum}, '0);
        @(posedge clk); #2 n_rst = 1'b1;

        // Reset during ADD abandons the operation with no done pulse.
        @(posedge clk); #1;
        op_a = 16'hFFFF; op_b = 16'h0001; carry_in = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 n_rst = 1'b0;
        #1 check("rst_in_add", {done, busy, overflow, sum}, '0);
        done0 = done_seen;
        @(posedge clk); #2 n_rst = 1'b1;
        repeat (8) @(posedge clk);
        #1 check("rst_no_done", (W+1)'(done_seen), (W+1)'(done0));
        $display("op reset during ADD: busy %0d done count %0d", busy, done_seen - done0);

        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4);
        run_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 4);
        run_op("wrap", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4);

        // Start during ADD is ignored; start held through DONE re-enters ADD at once.
        @(posedge clk); #1;
        op_a = 16'h0001; op_b = 16'h0001; carry_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        op_a = 16'hAAAA; op_b = 16'h5555; start = 1'b1;
        @(posedge clk); #1;
        op_a = 16'h8000; op_b = 16'h8000;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
`ifdef ADDER_SEQ_EARLY_DONE_EN
        check("proto1_lat", (W+1)'(lat), (W+1)'(1));
`else
        check("proto1_lat", (W+1)'(lat), (W+1)'(4));
`endif
        check("proto1_res", {overflow, sum}, {1'b0, 16'h0002});
        $display("op proto1: 0001 + 0001 -> sum %h ovf %0d in %0d cycles", sum, overflow, lat);
        @(posedge clk); #1 start = 1'b0;
        check("proto2_reenter", (W+1)'(busy), (W+1)'(1));
        wait_done(lat);
        check("proto2_lat", (W+1)'(lat), (W+1)'(4));
        check("proto2_res", {overflow, sum}, {1'b1, 16'h0000});
        $display("op proto2: 8000 + 8000 -> sum %h ovf %0d in %0d cycles", sum, overflow, lat);

`ifdef ADDER_SEQ_EARLY_DONE_EN
        run_op("small", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1);
        run_op("carry2", 16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 3);
`else
        run_op("small", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 4);
        run_op("carry2", 16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 4);
`endif

        // Random sweep: every-cycle comparison against the model.
        @(posedge clk); #1;
        acc0 = accepted;
        done0 = done_seen;
        budget = 0;
        while ((accepted - acc0) < 2000 && budget < 60000) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 3) == 0) ra = ra & W'(16'h00FF);
            if ($urandom_range(0, 3) == 0) rb = rb & W'(16'h0FFF);
            op_a = ra; op_b = rb; carry_in = 1'($urandom);
            start = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            budget++;
        end
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("sweep_count", (W+1)'((accepted - acc0) >= 2000), (W+1)'(1));
        check("sweep_done_pulses", (W+1)'(done_seen - done0), (W+1)'(accepted - acc0));
        $display("op sweep: %0d accepted, %0d done pulses in %0d cycles", accepted - acc0, done_seen - done0, budget);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
